// File: rtl/full_adder_pkg.sv
// Shared constants and reference math for the full-adder block.
package full_adder_pkg;
  // FAULT_MODE encodings
  localparam int FM_NONE     = 0;
  localparam int FM_SUM_INV  = 1;
  localparam int FM_COUT_SA0 = 2;
  localparam int FM_COUT_SA1 = 3;
  localparam int FM_SUM_SA0  = 4;
  localparam int FM_CIN_IGN  = 5;

  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_res_t;

  // Golden full-adder result.
  function automatic fa_res_t fa_ref(input logic a, input logic b, input logic cin);
    fa_res_t r;
    r.sum  = a ^ b ^ cin;
    r.cout = (a & b) | (cin & (a ^ b));
    return r;
  endfunction
endpackage

// File: rtl/full_adder_core.sv
// Combinational adder with selectable fault injection; also exposes the golden result.
module fa_core
  import full_adder_pkg::*;
#(
  parameter int FAULT_MODE = FM_NONE
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic fault_en,
  output logic sum,
  output logic cout,
  output logic ref_sum,
  output logic ref_cout
);
  fa_res_t golden;

  assign golden   = fa_ref(a, b, cin);
  assign ref_sum  = golden.sum;
  assign ref_cout = golden.cout;

  // Apply the selected fault only while fault_en is high; unknown modes act as no fault.
  always_comb begin
    sum  = golden.sum;
    cout = golden.cout;
    if (fault_en) begin
      case (FAULT_MODE)
        FM_SUM_INV:  sum  = ~golden.sum;
        FM_COUT_SA0: cout = 1'b0;
        FM_COUT_SA1: cout = 1'b1;
        FM_SUM_SA0:  sum  = 1'b0;
        FM_CIN_IGN: begin
          sum  = a ^ b;
          cout = a & b;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/incorr_full_adder.sv
// Permanently faulty stage: sum inverted, fault always enabled.
module incorr_full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             fault_en,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             mismatch_q,
  output logic [CNT_W-1:0] err_cnt
);
  // fault_en kept for port compatibility only; the fault is forced on.
  logic unused_fault_en;
  assign unused_fault_en = fault_en;

  full_adder #(.FAULT_MODE(FM_SUM_INV), .CNT_W(CNT_W)) u_fa (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .fault_en   (1'b1),
    .sum        (sum),
    .cout       (cout),
    .sum_q      (sum_q),
    .cout_q     (cout_q),
    .mismatch_q (mismatch_q),
    .err_cnt    (err_cnt)
  );
endmodule

// File: rtl/full_adder.sv
// Full adder with registered outputs, self-check flag and saturating error counter.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int FAULT_MODE = FM_NONE,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             fault_en,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             mismatch_q,
  output logic [CNT_W-1:0] err_cnt
);
  logic ref_sum, ref_cout, mismatch;

  fa_core #(.FAULT_MODE(FAULT_MODE)) u_core (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .fault_en (fault_en),
    .sum      (sum),
    .cout     (cout),
    .ref_sum  (ref_sum),
    .ref_cout (ref_cout)
  );

  assign mismatch = (sum != ref_sum) | (cout != ref_cout);

  // Capture outputs and self-check result each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= 1'b0;
      cout_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      sum_q      <= sum;
      cout_q     <= cout;
      mismatch_q <= mismatch;
    end
  end

  // Count mismatching edges, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (mismatch && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_full_adder.sv
// Directed bench: truth-table sweep, 8-bit ripple chains, fault/counter/reset sequences.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, cin = 1'b0;
  logic f3 = 1'b0, fs = 1'b0;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Mode-0 main DUT
  logic s0, c0, sq0, cq0, mq0;
  logic [15:0] ec0;
  full_adder u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .fault_en(1'b1),
    .sum(s0), .cout(c0), .sum_q(sq0), .cout_q(cq0), .mismatch_q(mq0), .err_cnt(ec0)
  );

  // Mode-3 DUT (cout stuck-at-1)
  logic s3, c3, sq3, cq3, mq3;
  logic [15:0] ec3;
  full_adder #(.FAULT_MODE(3)) u_m3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .fault_en(f3),
    .sum(s3), .cout(c3), .sum_q(sq3), .cout_q(cq3), .mismatch_q(mq3), .err_cnt(ec3)
  );

  // 2-bit counter DUT with sum inversion
  logic ss, cs, sqs, cqs, mqs;
  logic [1:0] ecs;
  full_adder #(.FAULT_MODE(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .fault_en(fs),
    .sum(ss), .cout(cs), .sum_q(sqs), .cout_q(cqs), .mismatch_q(mqs), .err_cnt(ecs)
  );

  // Two 8-bit ripple chains: all-good and bit 5 faulty
  logic [7:0] ra, rb;
  logic       rcin;
  logic [8:0] gc, bc;
  logic [7:0] gs, bs;
  logic [7:0] g_sq, g_cq, g_mq, b_sq, b_cq, b_mq;
  logic [7:0][15:0] g_ec, b_ec;

  assign gc[0] = rcin;
  assign bc[0] = rcin;

  for (genvar i = 0; i < 8; i++) begin : g_chain
    full_adder u_g (
      .clk(clk), .rst(rst), .a(ra[i]), .b(rb[i]), .cin(gc[i]), .fault_en(1'b0),
      .sum(gs[i]), .cout(gc[i+1]), .sum_q(g_sq[i]), .cout_q(g_cq[i]),
      .mismatch_q(g_mq[i]), .err_cnt(g_ec[i])
    );
    if (i == 5) begin : g_bad
      incorr_full_adder u_b (
        .clk(clk), .rst(rst), .a(ra[i]), .b(rb[i]), .cin(bc[i]), .fault_en(1'b0),
        .sum(bs[i]), .cout(bc[i+1]), .sum_q(b_sq[i]), .cout_q(b_cq[i]),
        .mismatch_q(b_mq[i]), .err_cnt(b_ec[i])
      );
    end else begin : g_ok
      full_adder u_b (
        .clk(clk), .rst(rst), .a(ra[i]), .b(rb[i]), .cin(bc[i]), .fault_en(1'b0),
        .sum(bs[i]), .cout(bc[i+1]), .sum_q(b_sq[i]), .cout_q(b_cq[i]),
        .mismatch_q(b_mq[i]), .err_cnt(b_ec[i])
      );
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } fa_vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [8:0] good, bad;
  } rip_vec_t;

  fa_vec_t  tt [8];
  rip_vec_t rt [4];

  initial begin
    tt[0] = '{0,0,0, 0,0};
    tt[1] = '{0,0,1, 1,0};
    tt[2] = '{0,1,0, 1,0};
    tt[3] = '{0,1,1, 0,1};
    tt[4] = '{1,0,0, 1,0};
    tt[5] = '{1,0,1, 0,1};
    tt[6] = '{1,1,0, 0,1};
    tt[7] = '{1,1,1, 1,1};

    rt[0] = '{8'd100, 8'd55,  1'b0, 9'd155, 9'd187};
    rt[1] = '{8'd255, 8'd255, 1'b1, 9'd511, 9'd479};
    rt[2] = '{8'd0,   8'd0,   1'b0, 9'd0,   9'd32};
    rt[3] = '{8'd1,   8'd1,   1'b0, 9'd2,   9'd34};
    ra = '0; rb = '0; rcin = 1'b0;

    // Reset state, and combinational path alive during reset
    a = 1; b = 1; cin = 0;
    #3;
    chk("rst_sum_q", sq0, 0);
    chk("rst_cout_q", cq0, 0);
    chk("rst_mismatch_q", mq0, 0);
    chk("rst_err_cnt", ec0, 0);
    chk("rst_comb_sum", s0, 0);
    chk("rst_comb_cout", c0, 1);
    @(negedge clk);
    rst = 0;

    // Exhaustive truth-table sweep, mode 0
    for (int i = 0; i < 8; i++) begin
      a = tt[i].a; b = tt[i].b; cin = tt[i].cin;
      #1;
      chk($sformatf("tt%0d_sum", i), s0, tt[i].sum);
      chk($sformatf("tt%0d_cout", i), c0, tt[i].cout);
      tick();
      chk($sformatf("tt%0d_sum_q", i), sq0, tt[i].sum);
      chk($sformatf("tt%0d_cout_q", i), cq0, tt[i].cout);
      chk($sformatf("tt%0d_mismatch_q", i), mq0, 0);
    end
    chk("tt_err_cnt", ec0, 0);

    // Ripple chains
    for (int i = 0; i < 4; i++) begin
      ra = rt[i].a; rb = rt[i].b; rcin = rt[i].cin;
      #1;
      chk($sformatf("rip%0d_good", i), {gc[8], gs}, rt[i].good);
      chk($sformatf("rip%0d_bad", i), {bc[8], bs}, rt[i].bad);
    end

    // Mode 3: cout stuck at 1 for three edges
    a = 0; b = 0; cin = 0; f3 = 1;
    #1;
    chk("m3_cout", c3, 1);
    chk("m3_sum", s3, 0);
    tick();
    chk("m3_mismatch_q_1", mq3, 1);
    chk("m3_err_1", ec3, 1);
    tick();
    tick();
    chk("m3_err_3", ec3, 3);
    chk("m3_cout_q", cq3, 1);
    f3 = 0;
    #1;
    chk("m3_cout_off", c3, 0);
    tick();
    chk("m3_mismatch_q_off", mq3, 0);
    chk("m3_err_hold", ec3, 3);
    tick();
    chk("m3_err_hold2", ec3, 3);

    // Saturation with a 2-bit counter
    fs = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("sat_err_3", ecs, 3);
    tick();
    tick();
    chk("sat_err_5", ecs, 3);
    chk("sat_mismatch_q", mqs, 1);

    // Asynchronous reset mid-cycle
    a = 1; b = 0; cin = 0;
    tick();
    chk("pre_rst_sum_q", sq0, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_sum_q", sq0, 0);
    chk("arst_m3_err", ec3, 0);
    chk("arst_sat_err", ecs, 0);
    chk("arst_mismatch_q", mqs, 0);
    chk("arst_comb_sum", s0, 1);
    @(negedge clk);
    rst = 0;
    tick();
    chk("resume_sat_err", ecs, 1);
    chk("resume_sum_q", sq0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: got stalled run, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter FAULT_MODE, default 0, selects the injected fault: 0 none, 1 sum inverted, 2 cout stuck-at-0, 3 cout stuck-at-1, 4 sum stuck-at-0, 5 carry-in ignored.
REQ-002 Parameter CNT_W, default 16, is the error-counter width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port a, input, 1 bit: addend bit.
REQ-007 Port b, input, 1 bit: addend bit.
REQ-008 Port cin, input, 1 bit: carry in, chainable from the previous stage's cout.
REQ-009 Port fault_en, input, 1 bit: when high, FAULT_MODE is applied; when low, output is always correct.
REQ-010 Port sum, output, 1 bit: combinational sum.
REQ-011 Port cout, output, 1 bit: combinational carry out.
REQ-012 Port sum_q, output, 1 bit: registered sum.
REQ-013 Port cout_q, output, 1 bit: registered cout.
REQ-014 Port mismatch_q, output, 1 bit: registered self-check flag.
REQ-015 Port err_cnt, output, CNT_W bits: saturating mismatch count.

Function
REQ-016 Reference result: ref_sum = a^b^cin; ref_cout = (a&b)|(cin&(a^b)).
REQ-017 With fault_en=0 or FAULT_MODE=0, sum and cout SHALL equal the reference, with zero latency and no clock dependence.
REQ-018 Mode 1: sum = ~ref_sum; cout = ref_cout.
REQ-019 Mode 2: cout = 0; sum = ref_sum.
REQ-020 Mode 3: cout = 1; sum = ref_sum.
REQ-021 Mode 4: sum = 0; cout = ref_cout.
REQ-022 Mode 5: sum = a^b; cout = a&b.
REQ-023 Undefined FAULT_MODE values (6 and above) SHALL behave as mode 0.
REQ-024 On each rising clk edge, sum_q and cout_q SHALL capture sum and cout (1-cycle latency).
REQ-025 On each rising clk edge, mismatch_q SHALL capture (sum!=ref_sum)|(cout!=ref_cout).
REQ-026 err_cnt SHALL increment by 1 on each clock edge where a mismatch exists.
REQ-027 err_cnt SHALL saturate at all-ones, with no wrap-around.
REQ-028 Mismatch detection SHALL use the inputs present at that edge.
REQ-029 Input X/Z propagation is not required to be masked.

Reset
REQ-030 While rst is high, sum_q, cout_q, mismatch_q and err_cnt SHALL be 0, asynchronously and immediately.
REQ-031 Reset SHALL NOT affect the combinational sum or cout.
REQ-032 Counting SHALL resume on the first rising edge after rst deasserts.
REQ-033 A reset asserted mid-count SHALL clear err_cnt regardless of saturation.

Structure
REQ-034 Package full_adder_pkg SHALL hold the FAULT_MODE encodings as named constants and the default CNT_W.
REQ-035 Combinational logic SHALL sit in one sub-module, fa_core (a, b, cin, fault_en → sum, cout, ref_sum, ref_cout).
REQ-036 Registers and the counter SHALL sit in full_adder.
REQ-037 incorr_full_adder SHALL be a thin wrapper of full_adder with FAULT_MODE=1 and fault_en tied high, exposing the same ports.

Verification
REQ-038 Exhaustive 8-combination sweep, mode 0: sum/cout match the full-adder truth table, e.g. a=1,b=1,cin=1 → sum=1,cout=1; err_cnt stays 0.
REQ-039 8-bit ripple of stages, all correct: A=100,B=55,CIN=0 → 9-bit result 155; A=255,B=255,CIN=1 → 511.
REQ-040 Same 8-bit ripple with bit 5 as incorr_full_adder: A=100,B=55,CIN=0 → 187.
REQ-041 Same 8-bit ripple with bit 5 as incorr_full_adder: A=0,B=0,CIN=0 → 32.
REQ-042 Mode 3, fault_en=1, a=b=cin=0 for 3 cycles → cout=1, mismatch_q=1 after the first edge, err_cnt=3.
REQ-043 Mode 3: set fault_en=0 → mismatch_q=0 next edge, err_cnt holds.
REQ-044 CNT_W=2, persistent fault for 5 cycles → err_cnt=3 (saturated).
REQ-045 Assert rst mid-cycle → err_cnt=0 and sum_q=0 without a clock edge.
